multi_rate_circular_buffer: RTL and testbench

Parametrised circular buffer with internally tracked pointers and valid/ready handshakes on both sides. Each write accepts 1..K words and each read delivers 1..J words, with the length chosen per transfer. It sits between a wide producer stage and a consumer that takes a different number of words per transfer. It replaces externally addressed buffering with self-managed occupancy, full/empty status and flush.

---
 rtl/multi_rate_circular_buffer.sv | 144 ++++++++++++++
 tb/tb_multi_rate_circular_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rate_circular_buffer.sv
`default_nettype none
// ============================================================================
// Module   : multi_rate_circular_buffer
// Purpose  : Circular word buffer with self-managed read/write pointers and
//            occupancy. A write transfer stores 1..K words and a read
//            transfer removes 1..J words. The length is chosen per transfer.
//            SIZE does not need to be a power of two.
// Ports    : clk      - clock, rising edge active
//            rst      - asynchronous active-low reset
//            flush    - synchronous clear of pointers and count
//            wr_valid / wr_len / wr_data / wr_ready - producer side
//                       (lane 0 of wr_data is stored first)
//            rd_len / rd_ready / rd_valid / rd_data - consumer side
//                       (first-word fall-through; lanes >= rd_len read 0)
//            count / full / empty - registered occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module multi_rate_circular_buffer #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int J     = 4,
    parameter int PW    = $clog2(SIZE),
    parameter int CW    = $clog2(SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_valid,
    input  logic [$clog2(K+1)-1:0]   wr_len,
    input  logic [WIDTH*K-1:0]       wr_data,
    output logic                     wr_ready,
    input  logic [$clog2(J+1)-1:0]   rd_len,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH*J-1:0]       rd_data,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_wlw = $clog2(K + 1);
    localparam int c_rlw = $clog2(J + 1);
    localparam int c_sw  = CW + 1;      // count arithmetic with one bit of headroom
    localparam int c_pw1 = PW + 1;      // pointer arithmetic with one bit of headroom

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_wr_legal;
    logic             w_rd_legal;
    logic [CW:0]      w_wr_sum;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [CW:0]      w_count_next;

    // ptr + n modulo SIZE. Both operands are below SIZE, so one conditional
    // subtraction is exact even when SIZE is not a power of two.
    function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] ptr, input logic [PW:0] n);
        logic [PW:0] sum;
        sum = {1'b0, ptr} + n;
        if (sum >= c_pw1'(SIZE)) begin
            sum = sum - c_pw1'(SIZE);
        end
        return sum[PW-1:0];
    endfunction

    // Handshake qualification uses only the registered count, so a read in
    // the same cycle never frees space for a write (and vice versa).
    assign w_wr_legal = (wr_len != '0) && (wr_len <= c_wlw'(K));
    assign w_rd_legal = (rd_len != '0) && (rd_len <= c_rlw'(J));
    assign w_wr_sum   = c_sw'(r_count) + c_sw'(wr_len);
    assign wr_ready   = w_wr_legal && (w_wr_sum <= c_sw'(SIZE));
    assign rd_valid   = w_rd_legal && (c_sw'(r_count) >= c_sw'(rd_len));
    assign w_wr_fire  = wr_valid && wr_ready;
    assign w_rd_fire  = rd_ready && rd_valid;

    assign w_count_next = c_sw'(r_count)
                        + (w_wr_fire ? c_sw'(wr_len) : '0)
                        - (w_rd_fire ? c_sw'(rd_len) : '0);

    // Storage: each accepted lane lands on its own wrapped address. A flush
    // cycle drops the write but leaves existing contents in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire && !flush) begin
            for (int i = 0; i < K; i++) begin
                if (i < int'(wr_len)) begin
                    r_mem[f_wrap(r_wr_ptr, c_pw1'(i))] <= wr_data[WIDTH*i +: WIDTH];
                end
            end
        end
    end

    // Pointers and occupancy; flush overrides both transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= f_wrap(r_wr_ptr, c_pw1'(wr_len));
            end
            if (w_rd_fire) begin
                r_rd_ptr <= f_wrap(r_rd_ptr, c_pw1'(rd_len));
            end
            r_count <= w_count_next[CW-1:0];
            r_full  <= (w_count_next == c_sw'(SIZE));
            r_empty <= (w_count_next == '0);
        end
    end

    // First-word fall-through read lanes.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < J; i++) begin
            if (i < int'(rd_len)) begin
                rd_data[WIDTH*i +: WIDTH] = r_mem[f_wrap(r_rd_ptr, c_pw1'(i))];
            end
        end
    end

    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_multi_rate_circular_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_rate_circular_buffer
// Purpose  : Self-checking bench for multi_rate_circular_buffer. It uses two
//            instances: SIZE=16 (s16) and SIZE=10 (s10). A word-FIFO model
//            is checked every cycle, alongside hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_rate_circular_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_flush, a_wr_valid, a_rd_ready;
    logic [2:0]  a_wr_len, a_rd_len;
    logic [31:0] a_wr_data, a_rd_data;
    logic        a_wr_ready, a_rd_valid, a_full, a_empty;
    logic [4:0]  a_count;

    logic        b_flush, b_wr_valid, b_rd_ready;
    logic [2:0]  b_wr_len, b_rd_len;
    logic [31:0] b_wr_data, b_rd_data;
    logic        b_wr_ready, b_rd_valid, b_full, b_empty;
    logic [3:0]  b_count;

    multi_rate_circular_buffer #(.SIZE(16), .WIDTH(8), .K(4), .J(4)) u_dut16 (
        .clk(clk), .rst(rst), .flush(a_flush),
        .wr_valid(a_wr_valid), .wr_len(a_wr_len), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
        .rd_len(a_rd_len), .rd_ready(a_rd_ready), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .count(a_count), .full(a_full), .empty(a_empty)
    );

    multi_rate_circular_buffer #(.SIZE(10), .WIDTH(8), .K(4), .J(4)) u_dut10 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .wr_valid(b_wr_valid), .wr_len(b_wr_len), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .rd_len(b_rd_len), .rd_ready(b_rd_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a plain word FIFO per instance (head index + occupancy).
    int          m_head [2];
    int          m_cnt  [2];
    logic [7:0]  m_data [2][64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic model_step(input int id, input int size, input logic fl, input logic wv,
                              input int wl, input logic [31:0] wd, input logic rr, input int rl);
        int   tail;
        logic wf, rf;
        wf = wv && (wl >= 1) && (wl <= 4) && (m_cnt[id] + wl <= size);
        rf = rr && (rl >= 1) && (rl <= 4) && (m_cnt[id] >= rl);
        if (fl) begin
            m_cnt[id]  = 0;
            m_head[id] = 0;
        end else begin
            tail = (m_head[id] + m_cnt[id]) % 64;
            if (wf) begin
                for (int i = 0; i < wl; i++) m_data[id][(tail + i) % 64] = wd[8*i +: 8];
                m_cnt[id] += wl;
            end
            if (rf) begin
                m_head[id] = (m_head[id] + rl) % 64;
                m_cnt[id] -= rl;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_step(0, 16, a_flush, a_wr_valid, int'(a_wr_len), a_wr_data, a_rd_ready, int'(a_rd_len));
            model_step(1, 10, b_flush, b_wr_valid, int'(b_wr_len), b_wr_data, b_rd_ready, int'(b_rd_len));
        end
    end

    always @(negedge rst) begin
        m_cnt[0] = 0; m_head[0] = 0;
        m_cnt[1] = 0; m_head[1] = 0;
    end

    task automatic cmp_one(input int id, input int size, input int cnt, input logic fu,
                           input logic em, input logic wr, input logic rv,
                           input logic [31:0] rd, input int wl, input int rl);
        logic [31:0] e_data;
        logic        e_wr, e_rv;
        string       p;
        p    = (id == 0) ? "s16" : "s10";
        e_wr = (wl >= 1) && (wl <= 4) && (m_cnt[id] + wl <= size);
        e_rv = (rl >= 1) && (rl <= 4) && (m_cnt[id] >= rl);
        chk({p, ".count"},    32'(cnt), 32'(m_cnt[id]));
        chk({p, ".full"},     32'(fu),  32'(m_cnt[id] == size));
        chk({p, ".empty"},    32'(em),  32'(m_cnt[id] == 0));
        chk({p, ".wr_ready"}, 32'(wr),  32'(e_wr));
        chk({p, ".rd_valid"}, 32'(rv),  32'(e_rv));
        if (e_rv) begin
            e_data = '0;
            for (int i = 0; i < rl; i++) e_data[8*i +: 8] = m_data[id][(m_head[id] + i) % 64];
            chk({p, ".rd_data"}, rd, e_data);
        end else if (!rst) begin
            chk({p, ".rd_data_rst"}, rd, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        cmp_one(0, 16, int'(a_count), a_full, a_empty, a_wr_ready, a_rd_valid, a_rd_data,
                int'(a_wr_len), int'(a_rd_len));
        cmp_one(1, 10, int'(b_count), b_full, b_empty, b_wr_ready, b_rd_valid, b_rd_data,
                int'(b_wr_len), int'(b_rd_len));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;

    initial begin
        rst = 1'b1;
        a_flush = 0; a_wr_valid = 0; a_rd_ready = 0; a_wr_len = 1; a_rd_len = 1; a_wr_data = '0;
        b_flush = 0; b_wr_valid = 0; b_rd_ready = 0; b_wr_len = 1; b_rd_len = 1; b_wr_data = '0;

        // Reset held low across two edges
        #1 rst = 1'b0;
        #1;
        chk("rst.count",    32'(a_count),    0);
        chk("rst.empty",    32'(a_empty),    1);
        chk("rst.rd_valid", 32'(a_rd_valid), 0);
        chk("rst.wr_ready", 32'(a_wr_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single write of 4, partial read view of 2
        a_wr_valid = 1; a_wr_len = 4; a_wr_data = 32'hA3A2A1A0;
        cyc();
        a_wr_valid = 0; a_rd_len = 2;
        #1;
        chk("t1.count",    32'(a_count),    4);
        chk("t1.rd_valid", 32'(a_rd_valid), 1);
        chk("t1.rd_data",  a_rd_data,       32'h0000A1A0);

        // Fill to SIZE, then overflow attempt with a concurrent read
        a_wr_valid = 1; a_wr_len = 4;
        for (int k = 0; k < 3; k++) begin
            a_wr_data = 32'hB3B2B1B0 + 32'h04040404 * k;
            cyc();
        end
        a_wr_valid = 0;
        #1;
        chk("fill.count", 32'(a_count), 16);
        chk("fill.full",  32'(a_full),  1);
        a_wr_valid = 1; a_wr_len = 1; a_wr_data = 32'h000000EE;
        a_rd_ready = 1; a_rd_len = 4;
        #1;
        chk("fill.wr_ready_full", 32'(a_wr_ready), 0);
        chk("fill.rd_valid",      32'(a_rd_valid), 1);
        chk("fill.rd_data",       a_rd_data,       32'hA3A2A1A0);
        cyc();
        a_wr_valid = 0; a_rd_ready = 0;
        #1;
        chk("fill.count_after", 32'(a_count),    12);
        chk("fill.wr_ready",    32'(a_wr_ready), 1);
        a_rd_ready = 1; a_rd_len = 4;
        repeat (3) cyc();
        a_rd_ready = 0;
        #1;
        chk("drain.empty", 32'(a_empty), 1);

        // Non-power-of-two wrap on SIZE=10
        b_wr_valid = 1; b_wr_len = 3;
        b_wr_data = 32'h00121110; cyc();
        b_wr_data = 32'h00151413; cyc();
        b_wr_data = 32'h00181716; cyc();
        b_wr_valid = 0; b_rd_ready = 1; b_rd_len = 4;
        cyc();
        b_rd_ready = 0; b_wr_valid = 1; b_wr_data = 32'h00222120;
        cyc();
        b_wr_valid = 0;
        #1;
        chk("wrap.count",   32'(b_count), 8);
        chk("wrap.rd_data", b_rd_data,    32'h17161514);
        b_rd_ready = 1;
        cyc();
        chk("wrap.rd_data2", b_rd_data,    32'h22212018);
        chk("wrap.count2",   32'(b_count), 4);
        cyc();
        b_rd_ready = 0;
        #1;
        chk("wrap.empty", 32'(b_empty), 1);

        // Simultaneous write and read
        a_wr_valid = 1; a_wr_len = 4; a_wr_data = 32'hC3C2C1C0; cyc();
        a_wr_len = 1; a_wr_data = 32'h000000C4; cyc();
        a_wr_len = 3; a_wr_data = 32'h00D2D1D0; a_rd_ready = 1; a_rd_len = 4;
        #1;
        chk("sim.wr_ready", 32'(a_wr_ready), 1);
        chk("sim.rd_valid", 32'(a_rd_valid), 1);
        cyc();
        a_wr_valid = 0; a_rd_ready = 0;
        #1;
        chk("sim.count",   32'(a_count), 4);
        chk("sim.rd_data", a_rd_data,    32'hD2D1D0C4);
        for (int n = 0; n < 20; n++) begin
            a_wr_valid = 1'($urandom_range(0, 1));
            a_wr_len   = 3'($urandom_range(1, 4));
            a_wr_data  = $urandom;
            a_rd_ready = 1'($urandom_range(0, 1));
            a_rd_len   = 3'($urandom_range(1, 4));
            cyc();
        end
        a_wr_valid = 0; a_rd_ready = 0; a_wr_len = 1; a_rd_len = 1;
        cyc();

        // Illegal lengths cause no state change
        exp_cnt = m_cnt[0];
        a_wr_valid = 1; a_wr_len = 0;
        #1 chk("ill.wr_len0", 32'(a_wr_ready), 0);
        cyc();
        a_wr_len = 5;
        #1 chk("ill.wr_len5", 32'(a_wr_ready), 0);
        cyc();
        a_wr_valid = 0; a_wr_len = 1; a_rd_ready = 1; a_rd_len = 0;
        #1;
        chk("ill.rd_len0",   32'(a_rd_valid), 0);
        chk("ill.rd_data0",  a_rd_data,       32'h0);
        cyc();
        a_rd_ready = 0; a_rd_len = 1;
        #1 chk("ill.count", 32'(a_count), 32'(exp_cnt));

        // Flush, then flush together with a write
        a_flush = 1; cyc(); a_flush = 0;
        #1 chk("fl.empty0", 32'(a_empty), 1);
        a_wr_valid = 1; a_wr_len = 4; a_wr_data = 32'hE3E2E1E0; cyc();
        a_wr_len = 3; a_wr_data = 32'h00E6E5E4; cyc();
        a_wr_valid = 0;
        #1 chk("fl.count7", 32'(a_count), 7);
        a_flush = 1; a_wr_valid = 1; a_wr_len = 4; a_wr_data = 32'h99999999;
        cyc();
        a_flush = 0; a_wr_valid = 0;
        #1;
        chk("fl.count", 32'(a_count), 0);
        chk("fl.empty", 32'(a_empty), 1);

        // Asynchronous reset in the middle of operation
        a_wr_valid = 1; a_wr_len = 4; a_wr_data = 32'hF3F2F1F0; cyc();
        a_wr_len = 2; a_wr_data = 32'h0000F5F4; cyc();
        a_wr_valid = 0; a_rd_len = 4;
        #1;
        chk("ar.count6",  32'(a_count), 6);
        chk("ar.rd_data", a_rd_data,    32'hF3F2F1F0);
        #1 rst = 1'b0;
        #1;
        chk("ar.count0",   32'(a_count),    0);
        chk("ar.rd_data0", a_rd_data,       32'h0);
        chk("ar.rd_valid", 32'(a_rd_valid), 0);
        chk("ar.empty",    32'(a_empty),    1);
        @(posedge clk);
        #1 rst = 1'b1;
        a_wr_valid = 1; a_wr_len = 1; a_wr_data = 32'h000000F8;
        cyc();
        a_wr_valid = 0; a_rd_len = 1;
        #1;
        chk("ar.count1",   32'(a_count), 1);
        chk("ar.rd_data1", a_rd_data,    32'h000000F8);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
